// File: rtl/hazard_ctrl_if.sv
// Decode-stage hazard bus between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic                  ID_VALID;
  logic [REG_ADDR_W-1:0] ID_RS1;
  logic                  ID_RS1_USED;
  logic [REG_ADDR_W-1:0] ID_RS2;
  logic                  ID_RS2_USED;
  logic [REG_ADDR_W-1:0] ID_RD;
  logic                  ID_REGWRT;
  logic                  ID_MEMRD;
  logic                  EX_REDIRECT;
  logic                  STALL;
  logic                  BUBBLE;
  logic                  FLUSH;
  logic [CNT_W-1:0]      STALL_CNT;
  logic [1:0]            FWD_RS1_SEL;
  logic [1:0]            FWD_RS2_SEL;

  modport master (
    output ID_VALID, ID_RS1, ID_RS1_USED, ID_RS2, ID_RS2_USED,
           ID_RD, ID_REGWRT, ID_MEMRD, EX_REDIRECT,
    input  STALL, BUBBLE, FLUSH, STALL_CNT, FWD_RS1_SEL, FWD_RS2_SEL
  );

  modport slave (
    input  ID_VALID, ID_RS1, ID_RS1_USED, ID_RS2, ID_RS2_USED,
           ID_RD, ID_REGWRT, ID_MEMRD, EX_REDIRECT,
    output STALL, BUBBLE, FLUSH, STALL_CNT, FWD_RS1_SEL, FWD_RS2_SEL
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: write scoreboard, stall/bubble/flush, stall counter.
// Define HAZARD_FORWARD_EN to stall only on load-use and drive forwarding selects instead.
//
// state    | meaning
// ST_RUN   | no redirect penalty pending, flush counter is zero
// ST_FLUSH | flush counter nonzero, wrong-path instructions still being killed
module hazard_ctrl #(
  parameter int NUM_STAGES       = 3,
  parameter int REG_ADDR_W       = 5,
  parameter int REDIRECT_PENALTY = 2,
  parameter int CNT_W            = 16
) (
  input logic         CLK,
  input logic         RESET,
  hazard_ctrl_if.slave bus
);

  typedef enum logic {ST_RUN, ST_FLUSH} flush_st_t;

  localparam logic [3:0] PENALTY = 4'(REDIRECT_PENALTY);

  flush_st_t              state, state_nxt;
  logic [3:0]             flush_cnt, flush_cnt_nxt;
  logic [NUM_STAGES-1:0]  sb_valid;
  logic [REG_ADDR_W-1:0]  sb_rd [NUM_STAGES];
  logic [CNT_W-1:0]       stall_cnt;
  logic [NUM_STAGES-1:0]  match_rs1, match_rs2;
  logic                   hazard, stall, flush, insert;
  logic [1:0]             fwd_rs1, fwd_rs2;
`ifdef HAZARD_FORWARD_EN
  logic [NUM_STAGES-1:0]  sb_load;
`endif

  always_comb begin
    match_rs1 = '0;
    match_rs2 = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      match_rs1[i] = bus.ID_VALID && bus.ID_RS1_USED && (bus.ID_RS1 != '0) &&
                     sb_valid[i] && (sb_rd[i] == bus.ID_RS1);
      match_rs2[i] = bus.ID_VALID && bus.ID_RS2_USED && (bus.ID_RS2 != '0) &&
                     sb_valid[i] && (sb_rd[i] == bus.ID_RS2);
    end
  end

  // State register: flush FSM, scoreboard shift and stall counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      sb_valid  <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < NUM_STAGES; i++) sb_rd[i] <= '0;
`ifdef HAZARD_FORWARD_EN
      sb_load   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      sb_valid  <= {sb_valid[NUM_STAGES-2:0], insert};
      for (int i = 1; i < NUM_STAGES; i++) sb_rd[i] <= sb_rd[i-1];
      sb_rd[0]  <= insert ? bus.ID_RD : '0;
`ifdef HAZARD_FORWARD_EN
      sb_load   <= {sb_load[NUM_STAGES-2:0], insert & bus.ID_MEMRD};
`endif
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    flush_cnt_nxt = flush_cnt;
    if (bus.EX_REDIRECT)
      flush_cnt_nxt = PENALTY;
    else if (flush_cnt != '0)
      flush_cnt_nxt = flush_cnt - 4'd1;
    state_nxt = (flush_cnt_nxt != '0) ? ST_FLUSH : ST_RUN;
  end

  // Outputs are gated by RESET so they drop the instant reset asserts
  always_comb begin
    flush   = RESET && (bus.EX_REDIRECT || (state == ST_FLUSH));
`ifdef HAZARD_FORWARD_EN
    hazard  = (match_rs1[0] || match_rs2[0]) && sb_load[0];
`else
    hazard  = (|match_rs1) || (|match_rs2);
`endif
    stall   = RESET && hazard && !flush;
    insert  = bus.ID_VALID && bus.ID_REGWRT && (bus.ID_RD != '0) && !stall && !flush;
    fwd_rs1 = 2'd0;
    fwd_rs2 = 2'd0;
`ifdef HAZARD_FORWARD_EN
    // Walk oldest to youngest so the youngest producer wins
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (match_rs1[i]) fwd_rs1 = 2'(i + 1);
      if (match_rs2[i]) fwd_rs2 = 2'(i + 1);
    end
    if (stall || flush) begin
      fwd_rs1 = 2'd0;
      fwd_rs2 = 2'd0;
    end
`endif
  end

  assign bus.STALL       = stall;
  assign bus.BUBBLE      = stall || flush;
  assign bus.FLUSH       = flush;
  assign bus.STALL_CNT   = stall_cnt;
  assign bus.FWD_RS1_SEL = fwd_rs1;
  assign bus.FWD_RS2_SEL = fwd_rs2;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; second instance with a 4-bit counter for saturation.
module tb_hazard_ctrl;

  logic CLK;
  logic RESET;
  int   n_vec;
  int   n_miss;
  int   exp_cnt;

  hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus ();
  hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(4))  bus2 ();

  hazard_ctrl #(.NUM_STAGES(3), .REG_ADDR_W(5), .REDIRECT_PENALTY(2), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  hazard_ctrl #(.NUM_STAGES(3), .REG_ADDR_W(5), .REDIRECT_PENALTY(2), .CNT_W(4)) dut2 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld);
    bus.ID_VALID    = v;
    bus.ID_RS1      = r1;
    bus.ID_RS1_USED = u1;
    bus.ID_RS2      = r2;
    bus.ID_RS2_USED = u2;
    bus.ID_RD       = rd;
    bus.ID_REGWRT   = wr;
    bus.ID_MEMRD    = ld;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    exp_cnt = 0;
    RESET   = 1'b0;
    bus.EX_REDIRECT  = 1'b0;
    bus2.EX_REDIRECT = 1'b0;
    bus2.ID_VALID    = 1'b0;
    bus2.ID_RS1      = '0;
    bus2.ID_RS1_USED = 1'b0;
    bus2.ID_RS2      = '0;
    bus2.ID_RS2_USED = 1'b0;
    bus2.ID_RD       = '0;
    bus2.ID_REGWRT   = 1'b0;
    bus2.ID_MEMRD    = 1'b0;
    idle();
    #2;
    chk("rst_stall",  32'(bus.STALL), 0);
    chk("rst_bubble", 32'(bus.BUBBLE), 0);
    chk("rst_flush",  32'(bus.FLUSH), 0);
    chk("rst_cnt",    32'(bus.STALL_CNT), 0);
    chk("rst_fwd1",   32'(bus.FWD_RS1_SEL), 0);
    chk("rst_fwd2",   32'(bus.FWD_RS2_SEL), 0);
    @(negedge CLK);
    RESET = 1'b1;
    tick();

`ifndef HAZARD_FORWARD_EN
    // add x5,x1,x2 then sub x6,x5,x1: three stall cycles, issue on the fourth
    drive(1, 1, 1, 2, 1, 5, 1, 0);
    chk("raw_producer_stall", 32'(bus.STALL), 0);
    tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("raw_stall_c%0d", k), 32'(bus.STALL), 1);
      chk($sformatf("raw_bubble_c%0d", k), 32'(bus.BUBBLE), 1);
      chk($sformatf("raw_fwd_c%0d", k), 32'(bus.FWD_RS1_SEL), 0);
      tick();
    end
    chk("raw_issue_stall", 32'(bus.STALL), 0);
    exp_cnt = 3;
    chk("raw_cnt", 32'(bus.STALL_CNT), 32'(exp_cnt));
    tick();
`else
    // lw x5 then add x7,x5,x5: one load-use stall, then forward from M
    drive(1, 0, 0, 0, 0, 5, 1, 1);
    chk("lu_producer_stall", 32'(bus.STALL), 0);
    tick();
    drive(1, 5, 1, 5, 1, 7, 1, 0);
    chk("lu_stall", 32'(bus.STALL), 1);
    chk("lu_stall_fwd1", 32'(bus.FWD_RS1_SEL), 0);
    tick();
    chk("lu_issue_stall", 32'(bus.STALL), 0);
    chk("lu_fwd1", 32'(bus.FWD_RS1_SEL), 2);
    chk("lu_fwd2", 32'(bus.FWD_RS2_SEL), 2);
    exp_cnt = 1;
    chk("lu_cnt", 32'(bus.STALL_CNT), 32'(exp_cnt));
    tick();
    drive(1, 0, 0, 0, 0, 8, 1, 0);
    tick();
    drive(1, 8, 1, 0, 1, 9, 1, 0);
    chk("alu_fwd_stall", 32'(bus.STALL), 0);
    chk("alu_fwd1", 32'(bus.FWD_RS1_SEL), 1);
    chk("alu_fwd2_x0", 32'(bus.FWD_RS2_SEL), 0);
    tick();
`endif
    idle();
    repeat (3) tick();

    // write to x0 then read x0: never a hazard
    drive(1, 1, 0, 2, 0, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 3, 1, 0);
    chk("x0_stall_a", 32'(bus.STALL), 0);
    tick();
    chk("x0_stall_b", 32'(bus.STALL), 0);
    chk("x0_fwd", 32'(bus.FWD_RS1_SEL), 0);
    idle();
    repeat (3) tick();

    // single redirect pulse: FLUSH for 3 cycles, decode add x7 dropped
    bus.EX_REDIRECT = 1'b1;
    drive(1, 0, 0, 0, 0, 7, 1, 0);
    chk("redir_flush_c0", 32'(bus.FLUSH), 1);
    chk("redir_bubble_c0", 32'(bus.BUBBLE), 1);
    chk("redir_stall_c0", 32'(bus.STALL), 0);
    tick();
    bus.EX_REDIRECT = 1'b0;
    idle();
    chk("redir_flush_c1", 32'(bus.FLUSH), 1);
    tick();
    chk("redir_flush_c2", 32'(bus.FLUSH), 1);
    tick();
    drive(1, 7, 1, 0, 0, 8, 0, 0);
    chk("redir_flush_c3", 32'(bus.FLUSH), 0);
    chk("redir_no_insert_stall", 32'(bus.STALL), 0);
    chk("redir_no_insert_fwd", 32'(bus.FWD_RS1_SEL), 0);
    tick();
    idle();

    // back-to-back redirects: FLUSH for 4 cycles
    bus.EX_REDIRECT = 1'b1;
    #1;
    chk("redir2_flush_c0", 32'(bus.FLUSH), 1);
    tick();
    chk("redir2_flush_c1", 32'(bus.FLUSH), 1);
    tick();
    bus.EX_REDIRECT = 1'b0;
    #1;
    chk("redir2_flush_c2", 32'(bus.FLUSH), 1);
    tick();
    chk("redir2_flush_c3", 32'(bus.FLUSH), 1);
    tick();
    chk("redir2_flush_c4", 32'(bus.FLUSH), 0);
    repeat (3) tick();

    // hazard coincident with redirect: FLUSH wins, counter untouched
    drive(1, 0, 0, 0, 0, 9, 1, 1);
    tick();
    bus.EX_REDIRECT = 1'b1;
    drive(1, 9, 1, 0, 0, 10, 1, 0);
    chk("both_flush", 32'(bus.FLUSH), 1);
    chk("both_stall", 32'(bus.STALL), 0);
    chk("both_bubble", 32'(bus.BUBBLE), 1);
    tick();
    bus.EX_REDIRECT = 1'b0;
    idle();
    chk("both_cnt_a", 32'(bus.STALL_CNT), 32'(exp_cnt));
    repeat (3) tick();
    chk("both_cnt_b", 32'(bus.STALL_CNT), 32'(exp_cnt));

    // reset asserted in the middle of a stall
    drive(1, 0, 0, 0, 0, 5, 1, 1);
    tick();
    drive(1, 5, 1, 5, 1, 6, 1, 0);
    chk("mid_rst_pre_stall", 32'(bus.STALL), 1);
    RESET = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(bus.STALL), 0);
    chk("mid_rst_bubble", 32'(bus.BUBBLE), 0);
    chk("mid_rst_flush", 32'(bus.FLUSH), 0);
    chk("mid_rst_cnt", 32'(bus.STALL_CNT), 0);
    #2;
    RESET = 1'b1;
    #1;
    chk("post_rst_stall_a", 32'(bus.STALL), 0);
    tick();
    chk("post_rst_stall_b", 32'(bus.STALL), 0);
    idle();

    // 4-bit counter: self-dependent load x5,x5 held in decode keeps stalling
    bus2.ID_VALID    = 1'b1;
    bus2.ID_RS1      = 5'd5;
    bus2.ID_RS1_USED = 1'b1;
    bus2.ID_RD       = 5'd5;
    bus2.ID_REGWRT   = 1'b1;
    bus2.ID_MEMRD    = 1'b1;
    repeat (4) tick();
`ifndef HAZARD_FORWARD_EN
    chk("sat_cnt_early", 32'(bus2.STALL_CNT), 3);
`else
    chk("sat_cnt_early", 32'(bus2.STALL_CNT), 2);
`endif
    repeat (40) tick();
    chk("sat_cnt_full", 32'(bus2.STALL_CNT), 15);
    chk("sat_main_cnt_clear", 32'(bus.STALL_CNT), 0);
    bus2.ID_VALID = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core (F, D, E, M, W).
- Keeps a scoreboard of in-flight register writes and compares it against the source registers of the instruction in decode.
- Drives STALL (hold PC and FD), BUBBLE (inject NOP into DE) and FLUSH (kill wrong-path instructions after a taken branch or jump).
- Also keeps a saturating count of stall cycles for performance work.

Parameters:
- NUM_STAGES, 3, number of scoreboard entries tracked past decode (entry 0 = E, 1 = M, 2 = W).
- REG_ADDR_W, 5, register address width.
- REDIRECT_PENALTY, 2, number of cycles FLUSH stays asserted after a redirect; legal range 1-15.
- CNT_W, 16, width of the stall counter.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  reset, asynchronous, active-low.
- ID_VALID  in  1  decode stage holds a valid instruction.
- ID_RS1  in  REG_ADDR_W  decode rs1.
- ID_RS1_USED  in  1  instruction reads rs1.
- ID_RS2  in  REG_ADDR_W  decode rs2.
- ID_RS2_USED  in  1  instruction reads rs2.
- ID_RD  in  REG_ADDR_W  decode rd.
- ID_REGWRT  in  1  instruction writes rd.
- ID_MEMRD  in  1  instruction is a load.
- EX_REDIRECT  in  1  taken branch or jump resolved in E this cycle.
- STALL  out  1  hold PC and FD registers.
- BUBBLE  out  1  load NOP into DE.
- FLUSH  out  1  invalidate FD and DE contents.
- STALL_CNT  out  CNT_W  saturating count of STALL cycles.
- FWD_RS1_SEL  out  2  forwarding select for rs1: 0 = regfile, 1 = E, 2 = M, 3 = W.
- FWD_RS2_SEL  out  2  forwarding select for rs2, same encoding as FWD_RS1_SEL.

Behaviour:
- Reset values (RESET=0, asynchronous):
  - all scoreboard entries invalid.
  - flush counter = 0.
  - STALL_CNT = 0.
  - STALL, BUBBLE, FLUSH, FWD_*_SEL all read 0.
- Scoreboard entry fields: {valid, rd, is_load}.
- Scoreboard update, every posedge:
  - entry[i+1] <= entry[i]; the oldest entry is discarded.
  - entry[0] <= {1, ID_RD, ID_MEMRD} when all of these hold: ID_VALID, ID_REGWRT, ID_RD != 0, !STALL, !FLUSH.
  - Otherwise entry[0] <= invalid.
- Source match, rsX:
  - requires ID_VALID, rsX_USED, rsX != 0, and entry.valid with entry.rd == rsX.
  - x0 never matches.
- Register file writes at the W clock edge, so a W-stage match is still a hazard.
- STALL without forwarding: STALL = (match on any entry 0..NUM_STAGES-1) & !FLUSH. This is combinational from the current decode inputs.
- BUBBLE = STALL | FLUSH.
- Flush counter:
  - EX_REDIRECT=1 loads the counter with REDIRECT_PENALTY.
  - Otherwise the counter decrements while nonzero.
  - FLUSH = EX_REDIRECT | (counter != 0).
  - A redirect while the counter is nonzero restarts it at REDIRECT_PENALTY.
- Priority: FLUSH overrides STALL. A simultaneous redirect and hazard gives FLUSH=1, STALL=0, and no scoreboard insert.
- STALL_CNT increments on every cycle with STALL=1 and saturates at all-ones. It has no wrap.
- Reset mid-stall or mid-flush: every output is 0 immediately on reset assertion. The first cycle after deassertion sees an empty scoreboard.
- FWD_*_SEL are tied to 0 when forwarding is compiled out.

Optional Feature:
- Macro name: HAZARD_FORWARD_EN.
- Defined:
  - STALL = (rs1 or rs2 matches entry[0] with is_load=1) & !FLUSH. This is the load-use hazard only.
  - Otherwise FWD_rsX_SEL = index+1 of the youngest matching entry (entry[0] has priority over 1, and 1 over 2), or 0 if no entry matches.
  - FWD_*_SEL are forced to 0 while STALL or FLUSH is asserted.
- Not defined: the full-scoreboard stall described in Behaviour; FWD_*_SEL = 0.

Test Plan:
- Back-to-back RAW, no forwarding: issue add x5 and then decode sub x6,x5,x1 -> STALL=1 for exactly 3 cycles and STALL_CNT=3; the sub issues on the 4th cycle.
- rd = x0: issue a write to x0 followed by a read of x0 -> STALL stays 0 and no scoreboard entry is created.
- Redirect with REDIRECT_PENALTY=2: EX_REDIRECT pulses for 1 cycle -> FLUSH=1 for 3 cycles (pulse cycle + 2); the decode instruction is not inserted; a second redirect on the following cycle extends FLUSH to 4 cycles total.
- Simultaneous hazard and redirect -> FLUSH=1, STALL=0, BUBBLE=1; STALL_CNT is unchanged.
- Reset mid-stall: assert RESET=0 during a 3-cycle stall -> STALL, BUBBLE and STALL_CNT read 0 immediately; after release, the same read does not stall.
- HAZARD_FORWARD_EN, load-use: lw x5 followed by add x7,x5,x5 -> STALL=1 for 1 cycle, then FWD_RS1_SEL=FWD_RS2_SEL=2. A non-load producer gives FWD=1 with no stall.
